// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage pipelined subtractor (A - B - bin) built from
// 4-bit carry-lookahead groups. Stage 1 produces the lower half of the
// difference and a carry, stage 2 the upper half and the status flags.
// Valid/ready handshake on both sides, full throughput, lossless stall.
module cla_sub_pipe #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int H  = DATA_WIDTH / 2;
    localparam int NG = H / 4;

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Half-width adder: chain of 4-bit lookahead groups, returns {carry_out, sum}
    function automatic logic [H:0] cla_half(input logic [H-1:0] a, input logic [H-1:0] b, input logic cin);
        logic         c;
        logic [4:0]   grp;
        logic [H-1:0] s;
        c = cin;
        s = {H{1'b0}};
        for (int i = 0; i < NG; i++) begin
            grp          = cla4(a[4*i +: 4], b[4*i +: 4], c);
            s[4*i +: 4]  = grp[3:0];
            c            = grp[4];
        end
        return {c, s};
    endfunction

    // pipeline state
    logic                  s1_v_q,    s1_v_d;
    logic [H-1:0]          s1_lo_q,   s1_lo_d;
    logic                  s1_c_q,    s1_c_d;
    logic [H-1:0]          s1_ahi_q,  s1_ahi_d;
    logic [H-1:0]          s1_nbhi_q, s1_nbhi_d;
    logic                  s2_v_q,    s2_v_d;
    logic [DATA_WIDTH-1:0] diff_q,    diff_d;
    logic                  bout_q,    bout_d;
    logic                  ovf_q,     ovf_d;
    logic                  zero_q,    zero_d;

    // handshake and datapath intermediates
    logic                  s2_load_s;
    logic                  s1_adv_s;
    logic                  in_ready_s;
    logic                  in_fire_s;
    logic [H:0]            lo_res_s;
    logic [H:0]            hi_res_s;
    logic [DATA_WIDTH-1:0] diff_full_s;
    logic                  a_msb_s;
    logic                  b_msb_s;

    // Flow control: stage 2 drains or is empty -> everything behind it may move
    always_comb begin
        s2_load_s  = !s2_v_q || out_ready;
        s1_adv_s   = s1_v_q && s2_load_s;
        in_ready_s = !s1_v_q || s2_load_s;
        in_fire_s  = in_valid && in_ready_s;
    end

    // Lower half of A + ~B + ~bin, carry kept for the upper half
    always_comb begin
        lo_res_s = cla_half(A[H-1:0], ~B[H-1:0], ~bin);
    end

    // Stage 1 next state: capture operands only on an accepted beat
    always_comb begin
        s1_lo_d   = s1_lo_q;
        s1_c_d    = s1_c_q;
        s1_ahi_d  = s1_ahi_q;
        s1_nbhi_d = s1_nbhi_q;
        s1_v_d    = s1_v_q;
        if (in_fire_s) begin
            s1_v_d    = 1'b1;
            s1_lo_d   = lo_res_s[H-1:0];
            s1_c_d    = lo_res_s[H];
            s1_ahi_d  = A[DATA_WIDTH-1:H];
            s1_nbhi_d = ~B[DATA_WIDTH-1:H];
        end else if (s1_adv_s) begin
            s1_v_d    = 1'b0;
        end else begin
            s1_v_d    = s1_v_q;
        end
    end

    // Upper half from the registered carry, then the status flags
    always_comb begin
        hi_res_s    = cla_half(s1_ahi_q, s1_nbhi_q, s1_c_q);
        diff_full_s = {hi_res_s[H-1:0], s1_lo_q};
        a_msb_s     = s1_ahi_q[H-1];
        b_msb_s     = ~s1_nbhi_q[H-1];
    end

    // Stage 2 next state: load from stage 1 when the output slot frees up
    always_comb begin
        s2_v_d = s2_v_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (s2_load_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                diff_d = diff_full_s;
                bout_d = ~hi_res_s[H];
                ovf_d  = (a_msb_s != b_msb_s) && (diff_full_s[DATA_WIDTH-1] != a_msb_s);
                zero_d = (diff_full_s == {DATA_WIDTH{1'b0}});
            end else begin
                diff_d = diff_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline registers, cleared asynchronously so no stale beat survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_lo_q   <= {H{1'b0}};
            s1_c_q    <= 1'b0;
            s1_ahi_q  <= {H{1'b0}};
            s1_nbhi_q <= {H{1'b0}};
            s2_v_q    <= 1'b0;
            diff_q    <= {DATA_WIDTH{1'b0}};
            bout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_lo_q   <= s1_lo_d;
            s1_c_q    <= s1_c_d;
            s1_ahi_q  <= s1_ahi_d;
            s1_nbhi_q <= s1_nbhi_d;
            s2_v_q    <= s2_v_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: directed vectors with hand-computed results; a
// scoreboard queue holds expected beats, a monitor pops them on each output.
module tb_cla_sub_pipe;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bi;
        logic [63:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    vec_t vecs[15];
    int   sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;

    cla_sub_pipe #(.DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid and ready are seen here
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                int k;
                k = sb_q.pop_front();
                check($sformatf("diff[v%0d]", k), diff, vecs[k].d);
                check($sformatf("bout[v%0d]", k), {63'd0, bout}, {63'd0, vecs[k].bo});
                check($sformatf("ovf[v%0d]", k),  {63'd0, ovf},  {63'd0, vecs[k].ov});
                check($sformatf("zero[v%0d]", k), {63'd0, zero}, {63'd0, vecs[k].z});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int k);
        A        = vecs[k].a;
        B        = vecs[k].b;
        bin      = vecs[k].bi;
        in_valid = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        step();
        check({name, "_idle"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc;
        int n_before;

        vecs[0]  = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{64'h0000_0001_0000_0000, 64'd0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{64'd100, 64'd1, 1'b0, 64'd99,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{64'd200, 64'd1, 1'b0, 64'd199, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{64'd300, 64'd1, 1'b0, 64'd299, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{64'd400, 64'd1, 1'b0, 64'd399, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{64'hDEAD_BEEF_0000_0000, 64'd1, 1'b0, 64'hDEAD_BEEE_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 64'd0;
        B         = 64'd0;
        bin       = 1'b0;

        // reset state, with the clock running
        #22;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_diff",      diff,               64'd0);
        check("rst_flags",     {61'd0, bout, ovf, zero}, 64'd0);
        step();
        rst_n = 1'b1;

        // single beat latency: presented in cycle 0, valid in cycle 2
        present(0);
        @(negedge clk);
        check("lat_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.push_back(0);
        step();
        in_valid = 1'b0;
        A = 64'hFFFF_FFFF_FFFF_FFFF;
        check("lat_cycle1_out_valid", {63'd0, out_valid}, 64'd0);
        step();
        check("lat_cycle2_out_valid", {63'd0, out_valid}, 64'd1);
        wait_drain("latency");

        // back-to-back stream, one beat per cycle, no bubbles
        for (int i = 1; i <= 9; i++) begin
            step();
            present(i);
            @(negedge clk);
            check("thru_in_ready", {63'd0, in_ready}, 64'd1);
            if (in_ready) sb_q.push_back(i);
            if (i >= 3) check("no_bubble", {63'd0, out_valid}, 64'd1);
        end
        step();
        in_valid = 1'b0;
        wait_drain("stream");

        // back-pressure: consumer stalled for 4 cycles while beats keep coming
        k   = 10;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            out_ready = 1'b0;
            present(k);
            @(negedge clk);
            if (c >= 2) begin
                check("bp_in_ready_low",   {63'd0, in_ready},  64'd0);
                check("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
                check("bp_diff_stable",    diff,               64'd99);
            end
            if (in_ready) begin
                sb_q.push_back(k);
                k++;
                acc++;
            end
        end
        check("bp_accepted", 64'(acc), 64'd2);
        for (int c = 0; c < 20 && k < 14; c++) begin
            step();
            out_ready = 1'b1;
            present(k);
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(k);
                k++;
            end
        end
        check("bp_all_sent", 64'(k), 64'd14);
        step();
        in_valid = 1'b0;
        wait_drain("backpressure");

        // reset with both stages full: in-flight beats must vanish
        out_ready = 1'b0;
        present(0);
        @(negedge clk);
        sb_q.push_back(0);
        step();
        present(1);
        @(negedge clk);
        sb_q.push_back(1);
        step();
        in_valid = 1'b0;
        check("prefill_out_valid", {63'd0, out_valid}, 64'd1);
        check("prefill_in_ready",  {63'd0, in_ready},  64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_diff",      diff,               64'd0);
        check("midrst_flags",     {61'd0, bout, ovf, zero}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
        sb_q.delete();
        step();
        check("midrst_hold_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_before  = n_out;
        present(14);
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.push_back(14);
        step();
        in_valid = 1'b0;
        wait_drain("post_reset");
        step();
        step();
        check("post_rst_out_count", 64'(n_out - n_before), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
